mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-003 Parameter MAX_DATA_BURST, default 4, max consecutive data grants while a fetch waits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 IReq_i  in  1  fetch request; held until IAck_o.
REQ-007 IAddr_i  in  ADDR_WIDTH  fetch address; stable while IReq_i high.
REQ-008 IRdata_o  out  DATA_WIDTH  fetch read data, valid with IAck_o.
REQ-009 IAck_o  out  1  one-cycle fetch completion pulse.
REQ-010 DReq_i, DWe_i  in  1 each  data request; write when DWe_i=1.
REQ-011 DAddr_i, DWdata_i, DByteEn_i  in  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  data command; stable while DReq_i high.
REQ-012 DRdata_o, DAck_o  out  DATA_WIDTH, 1  data read data, one-cycle completion pulse.
REQ-013 MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o  out  1, 1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  registered shared-memory command.
REQ-014 MemRdata_i, MemAck_i  in  DATA_WIDTH, 1  memory read data and one-cycle completion.

Function
REQ-015 FSM states IDLE, GRANT_I, GRANT_D SHALL be used; reset state IDLE.
REQ-016 In IDLE, DReq_i wins if streak < MAX_DATA_BURST or IReq_i low; else IReq_i wins; no request stays IDLE.
REQ-017 Grant decision in cycle N SHALL drive MemReq_o=1 and latch the winner's command in cycle N+1 (one-cycle arbitration latency).
REQ-018 Mem command outputs SHALL stay constant in GRANT_x until MemAck_i.
REQ-019 On MemAck_i in GRANT_x, the matching xAck_o SHALL pulse the same cycle with xRdata_o = MemRdata_i (combinational pass-through); FSM returns to IDLE next cycle.
REQ-020 MemAck_i in IDLE SHALL be ignored; no ack pulse generated.
REQ-021 Streak counter: +1 per data grant while IReq_i high, cleared on fetch grant or when IReq_i low at a data grant, saturates at MAX_DATA_BURST.
REQ-022 Simultaneous IReq_i and DReq_i with streak=MAX_DATA_BURST SHALL grant fetch.
REQ-023 Requester deasserting request before its ack is illegal; bench SHALL flag via assertion; arbiter completes the memory transaction regardless.
REQ-024 xRdata_o SHALL be zero when xAck_o low.

Reset
REQ-025 On rst: state IDLE, streak 0, MemReq_o/MemWe_o/IAck_o/DAck_o 0, Mem address/data/byte-enable 0, counters 0.
REQ-026 Reset mid-transaction SHALL abandon it; MemReq_o low next cycle; in-flight MemAck_i ignored.

Configuration
REQ-027 Macro ARB_PERF_CNT_EN defined: 32-bit wrapping outputs IGrantCnt_o, DGrantCnt_o (per grant) and IStallCnt_o (cycles IReq_i high and IAck_o low) SHALL exist.
REQ-028 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package arb_pkg SHALL hold arb_state_t enum and the default MAX_DATA_BURST constant.
REQ-030 Performance counters SHALL live in sub-module arb_perf_cnt, instantiated only under ARB_PERF_CNT_EN.

Verification
REQ-031 Lone fetch 0x0000_0010, MemAck_i 2 cycles after MemReq_o, MemRdata_i=0x0000_0093 -> IAck_o pulse, IRdata_o=0x0000_0093, DAck_o never high.
REQ-032 IReq_i and DReq_i both high from reset, streak 0 -> data granted first, MemAddr_o=DAddr_i.
REQ-033 Continuous DReq_i and IReq_i, MAX_DATA_BURST=4 -> grant order D,D,D,D,I,D,...
REQ-034 Data write DAddr_i=0x100, DWdata_i=0xDEADBEEF, DByteEn_i=0x3 -> MemWe_o=1, MemByteEn_o=0x3, held until MemAck_i.
REQ-035 rst asserted while GRANT_D waits -> MemReq_o=0 next cycle; late MemAck_i produces no DAck_o.
REQ-036 With ARB_PERF_CNT_EN, 3 fetches and 2 data accesses -> IGrantCnt_o=3, DGrantCnt_o=2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the mem_arbiter slice.
//   arb_state_t        : arbiter FSM state encoding
//   ARB_MAX_DATA_BURST : default limit on consecutive data grants while a
//                        fetch is waiting
//   ARB_PERF_CNT_W     : width of the optional performance counters
//   streak_width()     : counter width able to hold 0..max_burst
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_DATA_BURST = 4;
    localparam int ARB_PERF_CNT_W     = 32;

    function automatic int streak_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the data port and the shared memory port of the
// arbiter. Signal names carry the arbiter's point of view (_i = into the
// arbiter, _o = out of the arbiter).
//   slave  : arbiter side
//   master : requester/memory side (testbench or surrounding system)
// Ports summary:
//   fetch  : IReq_i, IAddr_i, IRdata_o, IAck_o
//   data   : DReq_i, DWe_i, DAddr_i, DWdata_i, DByteEn_i, DRdata_o, DAck_o
//   memory : MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o,
//            MemRdata_i, MemAck_i
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  IReq_i;
    logic [ADDR_WIDTH-1:0] IAddr_i;
    logic [DATA_WIDTH-1:0] IRdata_o;
    logic                  IAck_o;

    logic                  DReq_i;
    logic                  DWe_i;
    logic [ADDR_WIDTH-1:0] DAddr_i;
    logic [DATA_WIDTH-1:0] DWdata_i;
    logic [BE_W-1:0]       DByteEn_i;
    logic [DATA_WIDTH-1:0] DRdata_o;
    logic                  DAck_o;

    logic                  MemReq_o;
    logic                  MemWe_o;
    logic [ADDR_WIDTH-1:0] MemAddr_o;
    logic [DATA_WIDTH-1:0] MemWdata_o;
    logic [BE_W-1:0]       MemByteEn_o;
    logic [DATA_WIDTH-1:0] MemRdata_i;
    logic                  MemAck_i;

    modport slave (
        input  IReq_i, IAddr_i,
        input  DReq_i, DWe_i, DAddr_i, DWdata_i, DByteEn_i,
        input  MemRdata_i, MemAck_i,
        output IRdata_o, IAck_o,
        output DRdata_o, DAck_o,
        output MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
    );

    modport master (
        output IReq_i, IAddr_i,
        output DReq_i, DWe_i, DAddr_i, DWdata_i, DByteEn_i,
        output MemRdata_i, MemAck_i,
        input  IRdata_o, IAck_o,
        input  DRdata_o, DAck_o,
        input  MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
    );

endinterface

// File: rtl/mem_arbiter_perf_cnt.sv
// -----------------------------------------------------------------------------
// arb_perf_cnt
// Free-running, wrapping performance counters for the arbiter. Only compiled
// when the ARB_PERF_CNT_EN macro is defined.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_grant_i       : one-cycle strobe per fetch grant
//   d_grant_i       : one-cycle strobe per data grant
//   i_stall_i       : fetch request pending and not acknowledged this cycle
//   i_grant_cnt_o   : number of fetch grants
//   d_grant_cnt_o   : number of data grants
//   i_stall_cnt_o   : number of fetch stall cycles
// -----------------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
module arb_perf_cnt
    import arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_grant_i,
    input  logic                      d_grant_i,
    input  logic                      i_stall_i,
    output logic [ARB_PERF_CNT_W-1:0] i_grant_cnt_o,
    output logic [ARB_PERF_CNT_W-1:0] d_grant_cnt_o,
    output logic [ARB_PERF_CNT_W-1:0] i_stall_cnt_o
);

    localparam logic [ARB_PERF_CNT_W-1:0] ONE = ARB_PERF_CNT_W'(1);

    logic [ARB_PERF_CNT_W-1:0] i_grant_q, i_grant_d;
    logic [ARB_PERF_CNT_W-1:0] d_grant_q, d_grant_d;
    logic [ARB_PERF_CNT_W-1:0] i_stall_q, i_stall_d;

    always_comb begin
        i_grant_d = i_grant_i ? i_grant_q + ONE : i_grant_q;
        d_grant_d = d_grant_i ? d_grant_q + ONE : d_grant_q;
        i_stall_d = i_stall_i ? i_stall_q + ONE : i_stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_q <= '0;
            d_grant_q <= '0;
            i_stall_q <= '0;
        end else begin
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            i_stall_q <= i_stall_d;
        end
    end

    assign i_grant_cnt_o = i_grant_q;
    assign d_grant_cnt_o = d_grant_q;
    assign i_stall_cnt_o = i_stall_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter (instruction fetch, data access) in front of a single
// shared memory port. Data normally wins, but after MAX_DATA_BURST consecutive
// data grants with a fetch waiting, the fetch is served next.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction in flight; arbitration happens here
// GRANT_I | fetch command on the memory port, waiting for MemAck_i
// GRANT_D | data command on the memory port, waiting for MemAck_i
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch, data and memory signals)
//   IGrantCnt_o, DGrantCnt_o, IStallCnt_o : performance counters, present
//              only when the ARB_PERF_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BURST = ARB_MAX_DATA_BURST
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [ARB_PERF_CNT_W-1:0] IGrantCnt_o,
    output logic [ARB_PERF_CNT_W-1:0] DGrantCnt_o,
    output logic [ARB_PERF_CNT_W-1:0] IStallCnt_o
`endif
);

    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int STREAK_W = streak_width(MAX_DATA_BURST);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    localparam logic [1:0] IDLE    = ARB_IDLE;
    localparam logic [1:0] GRANT_I = ARB_GRANT_I;
    localparam logic [1:0] GRANT_D = ARB_GRANT_D;

    logic [1:0]            state_q,  state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  mem_req_q,  mem_req_d;
    logic                  mem_we_q,   mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_be_q,   mem_be_d;

    logic grant_i;
    logic grant_d;
    logic ack_i;
    logic ack_d;

    // Arbitration: data wins unless the fetch has already waited through a
    // full burst of data grants.
    always_comb begin
        grant_d = (state_q == IDLE) && bus.DReq_i &&
                  ((streak_q < STREAK_MAX) || !bus.IReq_i);
        grant_i = (state_q == IDLE) && bus.IReq_i && !grant_d;
    end

    // Acks are suppressed while rst is high so a memory response racing the
    // reset cannot leak out to a requester whose transaction was abandoned.
    always_comb begin
        ack_i = (state_q == GRANT_I) && bus.MemAck_i && !rst;
        ack_d = (state_q == GRANT_D) && bus.MemAck_i && !rst;
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.DWe_i;
                    mem_addr_d  = bus.DAddr_i;
                    mem_wdata_d = bus.DWdata_i;
                    mem_be_d    = bus.DByteEn_i;
                    // The streak only grows while a fetch is actually waiting.
                    if (!bus.IReq_i) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_ONE;
                    end
                end else if (grant_i) begin
                    state_d     = GRANT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.IAddr_i;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_d    = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.MemAck_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign bus.MemReq_o    = mem_req_q;
    assign bus.MemWe_o     = mem_we_q;
    assign bus.MemAddr_o   = mem_addr_q;
    assign bus.MemWdata_o  = mem_wdata_q;
    assign bus.MemByteEn_o = mem_be_q;

    assign bus.IAck_o   = ack_i;
    assign bus.DAck_o   = ack_d;
    assign bus.IRdata_o = ack_i ? bus.MemRdata_i : '0;
    assign bus.DRdata_o = ack_d ? bus.MemRdata_i : '0;

`ifdef ARB_PERF_CNT_EN
    arb_perf_cnt u_perf_cnt (
        .clk           (clk),
        .rst           (rst),
        .i_grant_i     (grant_i),
        .d_grant_i     (grant_d),
        .i_stall_i     (bus.IReq_i && !ack_i),
        .i_grant_cnt_o (IGrantCnt_o),
        .d_grant_cnt_o (DGrantCnt_o),
        .i_stall_cnt_o (IStallCnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single transactions, hand
// sequences for burst ordering, idle acks and mid-transaction reset, then a
// randomized run against a transaction-level reference model. Performance
// counter checks are compiled when ARB_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXB = ARB_MAX_DATA_BURST;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] igc, dgc, isc;
`endif

    mem_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MAX_DATA_BURST (MAXB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .IGrantCnt_o (igc),
        .DGrantCnt_o (dgc),
        .IStallCnt_o (isc)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IReq_i     = 1'b0;
        bus.IAddr_i    = '0;
        bus.DReq_i     = 1'b0;
        bus.DWe_i      = 1'b0;
        bus.DAddr_i    = '0;
        bus.DWdata_i   = '0;
        bus.DByteEn_i  = '0;
        bus.MemAck_i   = 1'b0;
        bus.MemRdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // A requester must hold its request until it is acknowledged.
    logic i_pend = 1'b0;
    logic d_pend = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            i_pend <= 1'b0;
            d_pend <= 1'b0;
        end else begin
            if (i_pend) assert (bus.IReq_i) else $error("FAIL protocol: IReq_i dropped before IAck_o");
            if (d_pend) assert (bus.DReq_i) else $error("FAIL protocol: DReq_i dropped before DAck_o");
            i_pend <= bus.IReq_i && !bus.IAck_o;
            d_pend <= bus.DReq_i && !bus.DAck_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          is_fetch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            lat;
        logic [DW-1:0] rdata;
        logic          exp_we;
        logic [BW-1:0] exp_be;
        logic          exp_iack;
        logic          exp_dack;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.is_fetch) begin
            bus.IReq_i  = 1'b1;
            bus.IAddr_i = v.addr;
        end else begin
            bus.DReq_i    = 1'b1;
            bus.DWe_i     = v.we;
            bus.DAddr_i   = v.addr;
            bus.DWdata_i  = v.wdata;
            bus.DByteEn_i = v.be;
        end
        #1;
        check({t, " MemReq_o in decision cycle"}, 64'(bus.MemReq_o), 64'd0);
        tick();
        check({t, " MemReq_o one cycle later"}, 64'(bus.MemReq_o), 64'd1);
        check({t, " MemAddr_o"}, 64'(bus.MemAddr_o), 64'(v.addr));
        check({t, " MemWe_o"}, 64'(bus.MemWe_o), 64'(v.exp_we));
        if (!v.is_fetch) begin
            check({t, " MemByteEn_o"}, 64'(bus.MemByteEn_o), 64'(v.exp_be));
            check({t, " MemWdata_o"}, 64'(bus.MemWdata_o), 64'(v.wdata));
        end
        for (int k = 0; k < v.lat; k++) begin
            tick();
            check({t, " MemReq_o held"}, 64'(bus.MemReq_o), 64'd1);
            check({t, " MemAddr_o held"}, 64'(bus.MemAddr_o), 64'(v.addr));
            check({t, " MemWe_o held"}, 64'(bus.MemWe_o), 64'(v.exp_we));
            check({t, " acks low while waiting"}, 64'({bus.IAck_o, bus.DAck_o}), 64'd0);
            check({t, " rdata zero while waiting"}, 64'(bus.IRdata_o | bus.DRdata_o), 64'd0);
        end
        bus.MemAck_i   = 1'b1;
        bus.MemRdata_i = v.rdata;
        #1;
        check({t, " IAck_o"}, 64'(bus.IAck_o), 64'(v.exp_iack));
        check({t, " DAck_o"}, 64'(bus.DAck_o), 64'(v.exp_dack));
        if (v.is_fetch) begin
            check({t, " IRdata_o"}, 64'(bus.IRdata_o), 64'(v.exp_rdata));
            check({t, " DRdata_o zero"}, 64'(bus.DRdata_o), 64'd0);
        end else begin
            check({t, " DRdata_o"}, 64'(bus.DRdata_o), 64'(v.exp_rdata));
            check({t, " IRdata_o zero"}, 64'(bus.IRdata_o), 64'd0);
        end
        tick();
        idle_inputs();
        #1;
        check({t, " MemReq_o after ack"}, 64'(bus.MemReq_o), 64'd0);
        check({t, " acks after ack"}, 64'({bus.IAck_o, bus.DAck_o}), 64'd0);
    endtask

    // Reference model state for the randomized run.
    logic          m_busy;
    logic          m_own_d;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    int            m_run;

    initial begin
        int got [$];
        logic prev_req;
        int cyc;
        logic prev_ack_i, prev_ack_d;
        logic resp_busy;
        int resp_left;
        logic exp_ia, exp_da;
        logic d_win;

        //                 fetch we    addr          wdata          be    lat rdata          exp_we exp_be iack  dack  exp_rdata
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 2, 32'h0000_0093, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0000_0093};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 32'h0000_0055, 1'b1, 4'h3, 1'b0, 1'b1, 32'h0000_0055};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0, 4'h0, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0BAD_0BAD, 4'hF, 1, 32'h1234_5678, 1'b0, 4'hF, 1'b0, 1'b1, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'h0, 1, 32'hA5A5_A5A5, 1'b0, 4'h0, 1'b1, 1'b0, 32'hA5A5_A5A5};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset MemReq_o", 64'(bus.MemReq_o), 64'd0);
        check("reset MemWe_o", 64'(bus.MemWe_o), 64'd0);
        check("reset MemAddr_o", 64'(bus.MemAddr_o), 64'd0);
        check("reset MemWdata_o", 64'(bus.MemWdata_o), 64'd0);
        check("reset MemByteEn_o", 64'(bus.MemByteEn_o), 64'd0);
        check("reset acks", 64'({bus.IAck_o, bus.DAck_o}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

`ifdef ARB_PERF_CNT_EN
        check("perf IGrantCnt_o", 64'(igc), 64'd3);
        check("perf DGrantCnt_o", 64'(dgc), 64'd2);
        // Stall = decision cycle + wait cycles of each fetch: (1+2)+(1+0)+(1+1)
        check("perf IStallCnt_o", 64'(isc), 64'd6);
`endif

        // MemAck_i with nothing in flight
        bus.MemAck_i   = 1'b1;
        bus.MemRdata_i = 32'hFFFF_FFFF;
        #1;
        check("idle ack IAck_o/DAck_o", 64'({bus.IAck_o, bus.DAck_o}), 64'd0);
        check("idle ack rdata", 64'(bus.IRdata_o | bus.DRdata_o), 64'd0);
        tick();
        idle_inputs();
        #1;
        check("idle ack MemReq_o", 64'(bus.MemReq_o), 64'd0);

        // Continuous fetch + data: grant order D x MAXB, then I, repeating
        do_reset();
        bus.IReq_i    = 1'b1;
        bus.IAddr_i   = 32'h0000_0040;
        bus.DReq_i    = 1'b1;
        bus.DWe_i     = 1'b0;
        bus.DAddr_i   = 32'h0000_0200;
        bus.DByteEn_i = 4'hF;
        prev_req = 1'b0;
        cyc = 0;
        while (got.size() < 10 && cyc < 200) begin
            #1;
            if (bus.MemReq_o && !prev_req) begin
                got.push_back((bus.MemAddr_o == 32'h0000_0200) ? 1 : 0);
            end
            bus.MemAck_i = bus.MemReq_o && prev_req;
            prev_req = bus.MemReq_o && !bus.MemAck_i;
            tick();
            cyc++;
        end
        check("burst grants collected", 64'(got.size()), 64'd10);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("burst grant %0d is data", k), 64'(got[k]),
                  64'(((k % (MAXB + 1)) == MAXB) ? 0 : 1));
        end
        do_reset();

        // Reset while a data write waits for its memory ack
        bus.DReq_i    = 1'b1;
        bus.DWe_i     = 1'b1;
        bus.DAddr_i   = 32'h0000_0180;
        bus.DWdata_i  = 32'h1122_3344;
        bus.DByteEn_i = 4'hC;
        tick();
        check("rst seq MemReq_o granted", 64'(bus.MemReq_o), 64'd1);
        tick();
        check("rst seq MemReq_o waiting", 64'(bus.MemReq_o), 64'd1);
        rst = 1'b1;
        idle_inputs();
        tick();
        check("rst seq MemReq_o dropped", 64'(bus.MemReq_o), 64'd0);
        check("rst seq MemWe_o cleared", 64'(bus.MemWe_o), 64'd0);
        check("rst seq MemAddr_o cleared", 64'(bus.MemAddr_o), 64'd0);
        rst = 1'b0;
        bus.MemAck_i   = 1'b1;
        bus.MemRdata_i = 32'h0000_0077;
        #1;
        check("rst seq late ack DAck_o", 64'(bus.DAck_o), 64'd0);
        check("rst seq late ack DRdata_o", 64'(bus.DRdata_o), 64'd0);
        tick();
        bus.MemAck_i = 1'b0;
        #1;
        check("rst seq MemReq_o stays low", 64'(bus.MemReq_o), 64'd0);

        // Randomized run against the transaction-level model
        do_reset();
        m_busy = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_run = 0;
        prev_ack_i = 1'b0; prev_ack_d = 1'b0;
        resp_busy = 1'b0; resp_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (prev_ack_i) begin
                bus.IReq_i = 1'($urandom_range(0, 1));
                bus.IAddr_i = $urandom;
            end else if (!bus.IReq_i && $urandom_range(0, 2) == 0) begin
                bus.IReq_i = 1'b1;
                bus.IAddr_i = $urandom;
            end
            if (prev_ack_d) begin
                bus.DReq_i = 1'($urandom_range(0, 1));
            end else if (!bus.DReq_i && $urandom_range(0, 2) == 0) begin
                bus.DReq_i = 1'b1;
            end
            if (bus.DReq_i && (prev_ack_d || !d_pend)) begin
                bus.DWe_i     = 1'($urandom_range(0, 1));
                bus.DAddr_i   = $urandom;
                bus.DWdata_i  = $urandom;
                bus.DByteEn_i = 4'($urandom_range(0, 15));
            end
            bus.MemAck_i   = 1'b0;
            bus.MemRdata_i = '0;
            if (bus.MemReq_o) begin
                if (!resp_busy) begin
                    resp_busy = 1'b1;
                    resp_left = $urandom_range(0, 3);
                end
                if (resp_left == 0) begin
                    bus.MemAck_i   = 1'b1;
                    bus.MemRdata_i = $urandom;
                    resp_busy      = 1'b0;
                end else begin
                    resp_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.MemAck_i   = 1'b1;
                bus.MemRdata_i = $urandom;
            end
            #1;

            exp_ia = m_busy && !m_own_d && bus.MemAck_i;
            exp_da = m_busy &&  m_own_d && bus.MemAck_i;
            check("rand MemReq_o", 64'(bus.MemReq_o), 64'(m_busy));
            if (m_busy) begin
                check("rand MemAddr_o", 64'(bus.MemAddr_o), 64'(m_addr));
                check("rand MemWe_o", 64'(bus.MemWe_o), 64'(m_we));
                if (m_own_d) begin
                    check("rand MemWdata_o", 64'(bus.MemWdata_o), 64'(m_wdata));
                    check("rand MemByteEn_o", 64'(bus.MemByteEn_o), 64'(m_be));
                end
            end
            check("rand IAck_o", 64'(bus.IAck_o), 64'(exp_ia));
            check("rand DAck_o", 64'(bus.DAck_o), 64'(exp_da));
            check("rand IRdata_o", 64'(bus.IRdata_o), exp_ia ? 64'(bus.MemRdata_i) : 64'd0);
            check("rand DRdata_o", 64'(bus.DRdata_o), exp_da ? 64'(bus.MemRdata_i) : 64'd0);

            prev_ack_i = exp_ia;
            prev_ack_d = exp_da;
            if (m_busy) begin
                if (bus.MemAck_i) m_busy = 1'b0;
            end else if (bus.IReq_i || bus.DReq_i) begin
                d_win = bus.DReq_i && (!bus.IReq_i || m_run < MAXB);
                m_busy = 1'b1;
                if (d_win) begin
                    m_own_d = 1'b1;
                    m_we    = bus.DWe_i;
                    m_addr  = bus.DAddr_i;
                    m_wdata = bus.DWdata_i;
                    m_be    = bus.DByteEn_i;
                    m_run   = bus.IReq_i ? ((m_run < MAXB) ? m_run + 1 : m_run) : 0;
                end else begin
                    m_own_d = 1'b0;
                    m_we    = 1'b0;
                    m_addr  = bus.IAddr_i;
                    m_run   = 0;
                end
            end
            tick();
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
